// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the EX-stage divide sequencer.
package div_seq_ctrl_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    // Stall request encoding seen by the pipeline stall controller
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_CALC = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

    // Sign handling captured with the operands
    typedef struct packed {
        logic is_signed;
        logic neg_quot;
        logic neg_rem;
    } div_sign_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX <-> divider handshake: request/operands one way, stall and result the other.
interface div_seq_ctrl_if
    import div_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             div_req;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ex_hold;
    logic             cancel;
    logic             stallreq_for_ex;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // EX stage side
    modport master (
        output div_req, div_signed, dividend, divisor, ex_hold, cancel,
        input  stallreq_for_ex, result_valid, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  div_req, div_signed, dividend, divisor, ex_hold, cancel,
        output stallreq_for_ex, result_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq_ctrl_iter_core.sv
// Restoring radix-2 divider datapath: one shift-subtract-compare per step on magnitudes.
module div_seq_ctrl_iter_core
    import div_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend_mag,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);
    localparam int unsigned PR_W = WIDTH + 1;

    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dsor_q;
    logic [PR_W-1:0]  shifted_c;
    logic [WIDTH-1:0] diff_c;
    logic             fits_c;

    // Shifted partial remainder carries the extra bit; the difference always fits WIDTH when it is kept
    always_comb begin
        shifted_c = {prem_q, quot_q[WIDTH-1]};
        fits_c    = (shifted_c >= {1'b0, dsor_q});
        diff_c    = WIDTH'(shifted_c - {1'b0, dsor_q});
    end

    // Load magnitudes, then shift one quotient bit in per step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prem_q <= '0;
            quot_q <= '0;
            dsor_q <= '0;
        end else if (load) begin
            prem_q <= '0;
            quot_q <= dividend_mag;
            dsor_q <= divisor_mag;
        end else if (step) begin
            prem_q <= fits_c ? diff_c : shifted_c[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], fits_c};
        end
    end

    assign q = quot_q;
    assign r = prem_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// DIV/DIVU sequencer: operand capture, sign correction, stall generation and result hold.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int unsigned     WIDTH     = DIV_WIDTH,
    parameter logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{1'b1}}
)
(
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    div_state_e       state_nxt;
    div_sign_t        sign_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt_q;

    logic             latch_ops_c;
    logic             core_load_c;
    logic             core_step_c;
    logic             done_zero_c;
    logic             done_fix_c;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;
    logic [WIDTH-1:0] quot_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    logic             result_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    div_seq_ctrl_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .rst          (rst),
        .load         (core_load_c),
        .step         (core_step_c),
        .dividend_mag (a_mag_c),
        .divisor_mag  (b_mag_c),
        .q            (core_q),
        .r            (core_r)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and datapath controls; a flush overrides everything including hold
    always_comb begin
        state_nxt   = state_q;
        latch_ops_c = 1'b0;
        core_load_c = 1'b0;
        core_step_c = 1'b0;
        done_zero_c = 1'b0;
        done_fix_c  = 1'b0;
        if (bus.cancel) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (bus.div_req) begin
                        state_nxt   = DIV_PREP;
                        latch_ops_c = 1'b1;
                    end
                end
                DIV_PREP: begin
                    if (b_q == '0) begin
                        state_nxt   = DIV_DONE;
                        done_zero_c = 1'b1;
                    end else begin
                        state_nxt   = DIV_CALC;
                        core_load_c = 1'b1;
                    end
                end
                DIV_CALC: begin
                    core_step_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_nxt = DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    state_nxt  = DIV_DONE;
                    done_fix_c = 1'b1;
                end
                DIV_DONE: begin
                    if (!bus.ex_hold) begin
                        state_nxt = DIV_IDLE;
                    end
                end
                default: begin
                    state_nxt = DIV_IDLE;
                end
            endcase
        end
    end

    // Unsigned magnitudes for the core and sign post-correction of its result
    always_comb begin
        a_mag_c    = (sign_q.is_signed && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
        b_mag_c    = (sign_q.is_signed && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
        quot_fix_c = sign_q.neg_quot ? (~core_q + WIDTH'(1)) : core_q;
        rem_fix_c  = sign_q.neg_rem  ? (~core_r + WIDTH'(1)) : core_r;
    end

    // Operand capture and iteration counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (latch_ops_c) begin
                a_q              <= bus.dividend;
                b_q              <= bus.divisor;
                sign_q.is_signed <= bus.div_signed;
                sign_q.neg_quot  <= bus.div_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                sign_q.neg_rem   <= bus.div_signed & bus.dividend[WIDTH-1];
            end
            if (core_load_c) begin
                cnt_q <= '0;
            end else if (core_step_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Result registers update only on entry to DONE and hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_valid_q <= 1'b0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            div_by_zero_q  <= 1'b0;
        end else begin
            result_valid_q <= (state_nxt == DIV_DONE);
            if (done_zero_c) begin
                quotient_q    <= ZERO_QUOT;
                remainder_q   <= a_q;
                div_by_zero_q <= 1'b1;
            end else if (done_fix_c) begin
                quotient_q    <= quot_fix_c;
                remainder_q   <= rem_fix_c;
                div_by_zero_q <= 1'b0;
            end
        end
    end

    // Stall from the request cycle itself; released in DONE so EX can consume the result
    assign bus.stallreq_for_ex = (rst && bus.div_req && !bus.cancel && (state_q != DIV_DONE))
                                 ? STOP : NO_STOP;
    assign bus.result_valid    = result_valid_q;
    assign bus.quotient        = quotient_q;
    assign bus.remainder       = remainder_q;
    assign bus.div_by_zero     = div_by_zero_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed corner cases plus random DIV/DIVU traffic.
module tb_div_seq_ctrl;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst;

    div_seq_ctrl_if #(.WIDTH(W)) bus ();

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EX may only drop its request after the result or on a flush
    a_req_held: assert property (@(posedge clk) disable iff (!rst)
        $fell(bus.div_req) |-> ($past(bus.result_valid) || $past(bus.cancel)))
        else $error("div_req dropped before result");

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: plain integer division with truncation toward zero
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output exp_t e);
        longint sa;
        longint sb;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            e.q  = W'(sa / sb);
            e.r  = W'(sa % sb);
            e.dz = 1'b0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
    endtask

    // Monitor: compare every new result against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.result_valid && !mon_prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: result q=0x%08h with no pending request", bus.quotient);
                end else begin
                    e = sb_q.pop_front();
                    check("quotient", bus.quotient, e.q);
                    check("remainder", bus.remainder, e.r);
                    check("div_by_zero", W'(bus.div_by_zero), W'(e.dz));
                end
            end
            mon_prev = bus.result_valid;
        end
    end

    // One complete divide with stall/latency/hold checks
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
        exp_t e;
        int   cyc;
        int   stall_low;
        bit   got;
        ref_div(a, b, s, e);
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.div_req    = 1'b1;
        bus.div_signed = s;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.ex_hold    = (hold > 0);
        cyc = 0; stall_low = 0; got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                got = 1'b1;
                break;
            end
            if (!bus.stallreq_for_ex) stall_low++;
            cyc++;
            @(posedge clk); #1;
        end
        check("done_seen", W'(got), W'(1));
        check("latency", W'(cyc), (b == '0) ? W'(2) : W'(W + 3));
        check("stall_busy_low_cycles", W'(stall_low), W'(0));
        check("stall_in_done", W'(bus.stallreq_for_ex), W'(0));
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            if (h == hold) bus.ex_hold = 1'b0;
            @(negedge clk);
            check("hold_valid", W'(bus.result_valid), W'(1));
            check("hold_q", bus.quotient, e.q);
            check("hold_r", bus.remainder, e.r);
        end
        @(posedge clk); #1;
        bus.div_req = 1'b0;
        bus.ex_hold = 1'b0;
        @(negedge clk);
        check("valid_drop", W'(bus.result_valid), W'(0));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        int           rv_seen;

        rst            = 1'b0;
        bus.div_req    = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.ex_hold    = 1'b0;
        bus.cancel     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", W'(bus.result_valid), W'(0));
        check("rst_quot", bus.quotient, W'(0));
        check("rst_rem", bus.remainder, W'(0));
        check("rst_dz", W'(bus.div_by_zero), W'(0));
        check("rst_stall", W'(bus.stallreq_for_ex), W'(0));
        rst = 1'b1;

        // Directed corner cases
        do_div(32'd100, 32'd7, 1'b0, 0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_div(32'd5, 32'd0, 1'b1, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 3);

        // Flush during CALC step 10 (cycle 12 after accept)
        @(posedge clk); #1;
        bus.div_req    = 1'b1;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd1000;
        bus.divisor    = 32'd3;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
        end
        check("stall_before_cancel", W'(bus.stallreq_for_ex), W'(1));
        bus.cancel = 1'b1;
        #1;
        check("cancel_stall_same_cycle", W'(bus.stallreq_for_ex), W'(0));
        @(posedge clk); #1;
        bus.cancel  = 1'b0;
        bus.div_req = 1'b0;
        @(negedge clk);
        check("cancel_no_valid", W'(bus.result_valid), W'(0));
        do_div(32'd9, 32'd3, 1'b0, 0);

        // Async reset in the middle of CALC
        @(posedge clk); #1;
        bus.div_req    = 1'b1;
        bus.div_signed = 1'b1;
        bus.dividend   = 32'h1234_5678;
        bus.divisor    = 32'd77;
        repeat (10) @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.div_req = 1'b0;
        #1;
        check("midrst_valid", W'(bus.result_valid), W'(0));
        check("midrst_quot", bus.quotient, W'(0));
        check("midrst_rem", bus.remainder, W'(0));
        check("midrst_stall", W'(bus.stallreq_for_ex), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.result_valid) rv_seen++;
        end
        check("no_stale_valid", W'(rv_seen), W'(0));

        // Random traffic with occasional corner operands
        for (int k = 0; k < 10; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = W'($urandom_range(1, 20));
                2:       b = W'(0) - W'($urandom_range(1, 20));
                3:       b = '0;
                default: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            endcase
            s = 1'($urandom_range(0, 1));
            do_div(a, b, s, $urandom_range(0, 2));
        end

        check("sb_drained", W'(sb_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
